// File: rtl/sram_bist.sv
// March-style self-test sequencer for a 64 x 8 single-port SRAM.
// Writes a seed-derived pattern, reads it back, then repeats with the complement.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | waiting for i_start, RAM pins quiet
// ST_WR        | write exp(addr) to addr, one location per cycle
// ST_RD_LATCH  | present addr, RAM registers it
// ST_RD_SAMPLE | RAM drives latched word, compare at closing edge
// ST_DONE      | one-cycle completion pulse, o_pass valid
module sram_bist (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_seed,
    output logic       o_ce,
    output logic       o_rw,
    output logic [5:0] o_addr,
    output logic [7:0] o_wdata,
    output logic       o_wdata_oe,
    input  logic [7:0] i_rdata,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [7:0] o_err_cnt,
    output logic [5:0] o_fail_addr,
    output logic [7:0] o_fail_exp,
    output logic [7:0] o_fail_got,
    output logic       o_fail_pass
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_LATCH,
        ST_RD_SAMPLE,
        ST_DONE
    } state_t;

    localparam logic [5:0] LAST_ADDR = 6'd63;

    state_t     state, state_nxt;
    logic [5:0] addr, addr_nxt;
    logic       pass, pass_nxt;
    logic [7:0] seed, seed_nxt;

    logic       pass_flag_nxt;
    logic [7:0] err_cnt_nxt;
    logic [5:0] fail_addr_nxt;
    logic [7:0] fail_exp_nxt;
    logic [7:0] fail_got_nxt;
    logic       fail_pass_nxt;

    logic [7:0] exp_cur;
    logic [7:0] exp_nxt;
    logic       mismatch;
    logic       busy_nxt;

    function automatic logic [7:0] pattern(input logic [7:0] s,
                                           input logic [5:0] a,
                                           input logic       p);
        logic [7:0] v;
        v = s + {2'b00, a};
        return p ? ~v : v;
    endfunction

    assign exp_cur  = pattern(seed, addr, pass);
    assign exp_nxt  = pattern(seed_nxt, addr_nxt, pass_nxt);
    assign mismatch = (i_rdata != exp_cur);

    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr;
        pass_nxt      = pass;
        seed_nxt      = seed;
        pass_flag_nxt = o_pass;
        err_cnt_nxt   = o_err_cnt;
        fail_addr_nxt = o_fail_addr;
        fail_exp_nxt  = o_fail_exp;
        fail_got_nxt  = o_fail_got;
        fail_pass_nxt = o_fail_pass;

        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    seed_nxt      = i_seed;
                    err_cnt_nxt   = 8'd0;
                    fail_addr_nxt = 6'd0;
                    fail_exp_nxt  = 8'd0;
                    fail_got_nxt  = 8'd0;
                    fail_pass_nxt = 1'b0;
                    pass_flag_nxt = 1'b0;
                    pass_nxt      = 1'b0;
                    addr_nxt      = 6'd0;
                    state_nxt     = ST_WR;
                end
            end

            ST_WR: begin
                // 6-bit increment wraps 63 -> 0 ready for the read sweep
                addr_nxt = addr + 6'd1;
                if (addr == LAST_ADDR) begin
                    state_nxt = ST_RD_LATCH;
                end
            end

            ST_RD_LATCH: begin
                state_nxt = ST_RD_SAMPLE;
            end

            ST_RD_SAMPLE: begin
                if (mismatch) begin
                    err_cnt_nxt = o_err_cnt + 8'd1;
                    if (o_err_cnt == 8'd0) begin
                        fail_addr_nxt = addr;
                        fail_exp_nxt  = exp_cur;
                        fail_got_nxt  = i_rdata;
                        fail_pass_nxt = pass;
                    end
                end
                if (addr != LAST_ADDR) begin
                    addr_nxt  = addr + 6'd1;
                    state_nxt = ST_RD_LATCH;
                end else if (!pass) begin
                    pass_nxt  = 1'b1;
                    addr_nxt  = 6'd0;
                    state_nxt = ST_WR;
                end else begin
                    pass_flag_nxt = (err_cnt_nxt == 8'd0);
                    state_nxt     = ST_DONE;
                end
            end

            ST_DONE: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy_nxt = (state_nxt == ST_WR) || (state_nxt == ST_RD_LATCH) ||
                      (state_nxt == ST_RD_SAMPLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            addr  <= 6'd0;
            pass  <= 1'b0;
            seed  <= 8'd0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
            pass  <= pass_nxt;
            seed  <= seed_nxt;
        end
    end

    // RAM pins are registered from the next state so they line up with it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_ce        <= 1'b0;
            o_rw        <= 1'b0;
            o_addr      <= 6'd0;
            o_wdata     <= 8'd0;
            o_wdata_oe  <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_pass      <= 1'b0;
            o_err_cnt   <= 8'd0;
            o_fail_addr <= 6'd0;
            o_fail_exp  <= 8'd0;
            o_fail_got  <= 8'd0;
            o_fail_pass <= 1'b0;
        end else begin
            o_ce        <= (state_nxt == ST_WR) || (state_nxt == ST_RD_LATCH);
            o_rw        <= (state_nxt == ST_WR) || (state_nxt == ST_RD_SAMPLE);
            o_addr      <= busy_nxt ? addr_nxt : 6'd0;
            o_wdata     <= (state_nxt == ST_WR) ? exp_nxt : 8'd0;
            o_wdata_oe  <= (state_nxt == ST_WR);
            o_busy      <= busy_nxt;
            o_done      <= (state_nxt == ST_DONE);
            o_pass      <= pass_flag_nxt;
            o_err_cnt   <= err_cnt_nxt;
            o_fail_addr <= fail_addr_nxt;
            o_fail_exp  <= fail_exp_nxt;
            o_fail_got  <= fail_got_nxt;
            o_fail_pass <= fail_pass_nxt;
        end
    end

endmodule

// File: tb/tb_sram_bist.sv
// Bench for sram_bist: behavioural 64 x 8 RAM with optional stuck-at bit,
// cycle-schedule monitor and a per-location reference of the march result.
module tb_sram_bist;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_start = 1'b0;
    logic [7:0] i_seed = 8'd0;
    logic       o_ce, o_rw, o_wdata_oe;
    logic [5:0] o_addr;
    logic [7:0] o_wdata;
    logic [7:0] i_rdata;
    logic       o_busy, o_done, o_pass, o_fail_pass;
    logic [7:0] o_err_cnt, o_fail_exp, o_fail_got;
    logic [5:0] o_fail_addr;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 i_clk = ~i_clk;

    sram_bist dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_seed(i_seed),
        .o_ce(o_ce), .o_rw(o_rw), .o_addr(o_addr), .o_wdata(o_wdata),
        .o_wdata_oe(o_wdata_oe), .i_rdata(i_rdata), .o_busy(o_busy),
        .o_done(o_done), .o_pass(o_pass), .o_err_cnt(o_err_cnt),
        .o_fail_addr(o_fail_addr), .o_fail_exp(o_fail_exp),
        .o_fail_got(o_fail_got), .o_fail_pass(o_fail_pass)
    );

    // RAM model with an injectable stuck-at cell
    logic [7:0] mem [64];
    logic [5:0] lat = 6'd0;
    logic       flt_en = 1'b0;
    logic       flt_val = 1'b0;
    logic [5:0] flt_addr = 6'd0;
    logic [2:0] flt_bit = 3'd0;
    int         wr_count = 0;

    function automatic logic [7:0] stored(input logic [5:0] a, input logic [7:0] d);
        logic [7:0] m;
        m = 8'd1 << flt_bit;
        if (flt_en && a == flt_addr) return flt_val ? (d | m) : (d & ~m);
        return d;
    endfunction

    initial for (int i = 0; i < 64; i++) mem[i] = 8'd0;

    always @(posedge i_clk) begin
        if (o_ce && o_rw) begin
            mem[o_addr] <= stored(o_addr, o_wdata);
            wr_count <= wr_count + 1;
        end
        if (o_ce && !o_rw) lat <= o_addr;
    end

    assign i_rdata = (!o_ce && o_rw) ? mem[lat] : 8'h00;

    // results of the last run_bist
    int         done_cyc, done_cnt, sched_bad, busy_bad, contention, wr_after_rst;
    logic       d_pass, d_fp;
    logic [7:0] d_err, d_fe, d_fg;
    logic [5:0] d_fa;
    logic [7:0] wd_c1, wd_c2, wd_c64, wd_c256;
    logic [50:0] rst_snap;

    function automatic logic [7:0] pat(input logic [7:0] s, input int a, input int p);
        logic [7:0] v;
        v = s + 8'(a);
        return (p != 0) ? ~v : v;
    endfunction

    task automatic ref_model(input logic [7:0] s, output int e, output logic [5:0] fa,
                             output logic [7:0] fe, output logic [7:0] fg, output logic fp);
        logic [7:0] ex, got;
        e = 0; fa = 0; fe = 0; fg = 0; fp = 0;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < 64; a++) begin
                ex  = pat(s, a, p);
                got = stored(6'(a), ex);
                if (got != ex) begin
                    if (e == 0) begin
                        fa = 6'(a); fe = ex; fg = got; fp = (p != 0);
                    end
                    e++;
                end
            end
        end
    endtask

    // Runs one start and observes 400 cycles; cycle n is sampled at the negedge after E(n-1)
    task automatic run_bist(input logic [7:0] seed, input bit glitch, input int rst_at);
        int wr_snap;
        bit sched_on;
        bit exp_ce, exp_rw, exp_oe, chk_addr, chk_data, chk_rw;
        int a, k, p;
        done_cyc = -1; done_cnt = 0; sched_bad = 0; busy_bad = 0; contention = 0;
        wr_after_rst = 0; wr_snap = 0; rst_snap = '1;
        @(negedge i_clk);
        i_seed = seed;
        i_start = 1'b1;
        @(posedge i_clk);
        for (int n = 1; n <= 400; n++) begin
            @(negedge i_clk);
            i_start = glitch && (n == 10 || n == 385);
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = n; d_pass = o_pass; d_err = o_err_cnt;
                    d_fa = o_fail_addr; d_fe = o_fail_exp; d_fg = o_fail_got; d_fp = o_fail_pass;
                end
            end
            if (o_wdata_oe && o_rw && !o_ce) contention++;
            if (n == 1) wd_c1 = o_wdata;
            if (n == 2) wd_c2 = o_wdata;
            if (n == 64) wd_c64 = o_wdata;
            if (n == 256) wd_c256 = o_wdata;
            sched_on = (rst_at == 0) || (n <= rst_at);
            if (rst_at == 0 && o_busy !== (n <= 384)) busy_bad++;
            if (sched_on) begin
                chk_addr = 0; chk_data = 0; chk_rw = 1; a = 0; p = 0;
                if (n <= 64 || (n >= 193 && n <= 256)) begin
                    p = (n <= 64) ? 0 : 1;
                    a = (n <= 64) ? n - 1 : n - 193;
                    exp_ce = 1; exp_rw = 1; exp_oe = 1; chk_addr = 1; chk_data = 1;
                end else if (n <= 384) begin
                    k = (n <= 192) ? n - 65 : n - 257;
                    a = k / 2;
                    exp_oe = 0;
                    if (k % 2 == 0) begin
                        exp_ce = 1; exp_rw = 0; chk_addr = 1;
                    end else begin
                        exp_ce = 0; exp_rw = 1;
                    end
                end else begin
                    exp_ce = 0; exp_rw = 0; exp_oe = 0; chk_rw = 0;
                end
                if (o_ce !== exp_ce || o_wdata_oe !== exp_oe || (chk_rw && o_rw !== exp_rw) ||
                    (chk_addr && o_addr !== 6'(a)) || (chk_data && o_wdata !== pat(seed, a, p)))
                    sched_bad++;
            end
            if (rst_at != 0) begin
                if (n == rst_at) i_rst = 1'b1;
                if (n == rst_at + 1) begin
                    rst_snap = {o_ce, o_rw, o_addr, o_wdata, o_wdata_oe, o_busy, o_done, o_pass,
                                o_err_cnt, o_fail_addr, o_fail_exp, o_fail_got, o_fail_pass};
                    wr_snap = wr_count;
                end
                if (n == rst_at + 3) i_rst = 1'b0;
            end
        end
        if (rst_at != 0) wr_after_rst = wr_count - wr_snap;
    endtask

    task automatic test_reset();
        int wr0;
        bit active;
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        n_cmp++;
        if ({o_ce, o_rw, o_addr, o_wdata, o_wdata_oe, o_busy, o_done, o_pass, o_err_cnt,
             o_fail_addr, o_fail_exp, o_fail_got, o_fail_pass} !== 51'd0) begin
            n_fail++;
            $display("FAIL reset_values: outputs ce=%b rw=%b addr=%0h wd=%0h oe=%b busy=%b done=%b pass=%b err=%0d, required all 0",
                     o_ce, o_rw, o_addr, o_wdata, o_wdata_oe, o_busy, o_done, o_pass, o_err_cnt);
        end
        wr0 = wr_count; active = 0;
        repeat (20) begin
            @(negedge i_clk);
            if (o_ce || o_wdata_oe || o_busy) active = 1;
        end
        n_cmp++;
        if (active || wr_count != wr0) begin
            n_fail++;
            $display("FAIL reset_idle_quiet: activity=%0d writes=%0d, required 0/0", active, wr_count - wr0);
        end
    endtask

    task automatic test_clean();
        flt_en = 1'b0;
        run_bist(8'h3C, 1'b0, 0);
        n_cmp++; if (done_cyc !== 385) begin n_fail++; $display("FAIL clean_done_cycle: got %0d required 385", done_cyc); end
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL clean_done_count: got %0d required 1", done_cnt); end
        n_cmp++; if (d_pass !== 1'b1 || d_err !== 8'd0) begin n_fail++; $display("FAIL clean_result: pass=%b err=%0d required 1/0", d_pass, d_err); end
        n_cmp++; if (wd_c64 !== 8'h7B) begin n_fail++; $display("FAIL clean_wr_p0_63: got %0h required 7b", wd_c64); end
        n_cmp++; if (wd_c256 !== 8'h84) begin n_fail++; $display("FAIL clean_wr_p1_63: got %0h required 84", wd_c256); end
        n_cmp++; if (sched_bad !== 0) begin n_fail++; $display("FAIL clean_schedule: %0d bad cycles, required 0", sched_bad); end
        n_cmp++; if (busy_bad !== 0) begin n_fail++; $display("FAIL clean_busy: %0d bad cycles, required 0", busy_bad); end
        n_cmp++; if (contention !== 0) begin n_fail++; $display("FAIL clean_contention: %0d cycles, required 0", contention); end
    endtask

    task automatic test_wrap();
        flt_en = 1'b0;
        run_bist(8'hFF, 1'b0, 0);
        n_cmp++; if (wd_c1 !== 8'hFF) begin n_fail++; $display("FAIL wrap_addr0: got %0h required ff", wd_c1); end
        n_cmp++; if (wd_c2 !== 8'h00) begin n_fail++; $display("FAIL wrap_addr1: got %0h required 00", wd_c2); end
        n_cmp++; if (wd_c64 !== 8'h3E) begin n_fail++; $display("FAIL wrap_addr63: got %0h required 3e", wd_c64); end
        n_cmp++; if (d_pass !== 1'b1 || done_cyc !== 385) begin n_fail++; $display("FAIL wrap_pass: pass=%b done_cyc=%0d required 1/385", d_pass, done_cyc); end
        n_cmp++; if (sched_bad !== 0) begin n_fail++; $display("FAIL wrap_schedule: %0d bad cycles, required 0", sched_bad); end
    endtask

    task automatic test_stuck();
        flt_en = 1'b1; flt_val = 1'b0; flt_addr = 6'd5; flt_bit = 3'd3;
        run_bist(8'h00, 1'b0, 0);
        flt_en = 1'b0;
        n_cmp++; if (d_err !== 8'd1 || d_pass !== 1'b0) begin n_fail++; $display("FAIL stuck_count: err=%0d pass=%b required 1/0", d_err, d_pass); end
        n_cmp++; if (d_fa !== 6'd5) begin n_fail++; $display("FAIL stuck_fail_addr: got %0d required 5", d_fa); end
        n_cmp++; if (d_fe !== 8'hFA || d_fg !== 8'hF2) begin n_fail++; $display("FAIL stuck_fail_data: exp=%0h got=%0h required fa/f2", d_fe, d_fg); end
        n_cmp++; if (d_fp !== 1'b1) begin n_fail++; $display("FAIL stuck_fail_pass: got %b required 1", d_fp); end
    endtask

    task automatic test_start_while_busy();
        flt_en = 1'b0;
        run_bist(8'h5A, 1'b1, 0);
        n_cmp++; if (done_cyc !== 385 || done_cnt !== 1) begin n_fail++; $display("FAIL busy_start_done: cycle=%0d count=%0d required 385/1", done_cyc, done_cnt); end
        n_cmp++; if (busy_bad !== 0) begin n_fail++; $display("FAIL busy_start_busy: %0d bad cycles (incl. 386..400), required 0", busy_bad); end
        n_cmp++; if (sched_bad !== 0) begin n_fail++; $display("FAIL busy_start_schedule: %0d bad cycles, required 0", sched_bad); end
    endtask

    task automatic test_reset_mid();
        flt_en = 1'b0;
        run_bist(8'hA7, 1'b0, 100);
        n_cmp++; if (rst_snap !== 51'd0) begin n_fail++; $display("FAIL midrst_values: got %0h required 0", rst_snap); end
        n_cmp++; if (done_cnt !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses required 0", done_cnt); end
        n_cmp++; if (wr_after_rst !== 0) begin n_fail++; $display("FAIL midrst_no_write: got %0d writes required 0", wr_after_rst); end
        n_cmp++; if (sched_bad !== 0) begin n_fail++; $display("FAIL midrst_pre_schedule: %0d bad cycles, required 0", sched_bad); end
        run_bist(8'(($urandom)), 1'b0, 0);
        n_cmp++; if (done_cyc !== 385 || d_pass !== 1'b1 || d_err !== 8'd0) begin
            n_fail++; $display("FAIL midrst_rerun: done=%0d pass=%b err=%0d required 385/1/0", done_cyc, d_pass, d_err);
        end
    endtask

    task automatic test_random();
        logic [7:0] s, fe, fg;
        logic [5:0] fa;
        logic       fp;
        int         e;
        for (int it = 0; it < 6; it++) begin
            s        = 8'($urandom);
            flt_en   = ($urandom_range(0, 2) != 0);
            flt_val  = 1'($urandom);
            flt_addr = 6'($urandom);
            flt_bit  = 3'($urandom);
            ref_model(s, e, fa, fe, fg, fp);
            run_bist(s, 1'b0, 0);
            n_cmp++;
            if (done_cyc !== 385 || d_err !== 8'(e) || d_pass !== (e == 0) ||
                d_fa !== fa || d_fe !== fe || d_fg !== fg || d_fp !== fp || sched_bad !== 0) begin
                n_fail++;
                $display("FAIL random_%0d seed=%0h: done=%0d err=%0d pass=%b fail=%0d/%0h/%0h/%b sched=%0d required 385/%0d/%b/%0d/%0h/%0h/%b/0",
                         it, s, done_cyc, d_err, d_pass, d_fa, d_fe, d_fg, d_fp, sched_bad,
                         e, (e == 0), fa, fe, fg, fp);
            end
        end
        flt_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_wrap();
        test_stuck();
        test_start_while_busy();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_bist.md
# sram_bist

Built-in self-test sequencer that sits directly upstream of the 64 x 8 single-port static RAM and owns its control pins (chip enable, read/write, address, data bus). On a start pulse it runs a two-pass march over all 64 locations: write, then read back and compare. The first pass uses a seed-derived pattern and the second its complement. It reports pass/fail, an error count and the first failing location to the surrounding test logic.

## Interface
Parameters:
- none; geometry is fixed at 6-bit address and 8-bit data.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_start`  in  1  start request, sampled only in IDLE.
- `i_seed`  in  8  pattern seed, captured on accepted start.
- `o_ce`  out  1  RAM chip enable.
- `o_rw`  out  1  RAM read/write: 1 = write/drive phase, 0 = address-latch phase.
- `o_addr`  out  6  RAM address.
- `o_wdata`  out  8  write data for top-level tri-state bus driver.
- `o_wdata_oe`  out  1  bus driver enable; high only in write cycles.
- `i_rdata`  in  8  RAM data bus, read side.
- `o_busy`  out  1  test in progress.
- `o_done`  out  1  one-cycle pulse when test completes.
- `o_pass`  out  1  1 = last test had zero errors; held until next start.
- `o_err_cnt`  out  8  mismatch count of last test, 0..128.
- `o_fail_addr`  out  6  address of first mismatch.
- `o_fail_exp`  out  8  expected data at first mismatch.
- `o_fail_got`  out  8  read data at first mismatch.
- `o_fail_pass`  out  1  pass index (0/1) of first mismatch.

## Operation
- States: IDLE, WR, RD_LATCH, RD_SAMPLE, DONE.
- IDLE:
  - `o_ce`=0, `o_rw`=0, `o_wdata_oe`=0.
  - `i_start`=1 captures `i_seed`, clears `o_err_cnt`, all fail registers and `o_pass`, sets pass=0 and addr=0, then goes to WR.
- Expected data: exp = (`i_seed` + addr) mod 256 in pass 0; the bitwise inverse of that value in pass 1.
- WR:
  - Outputs `o_ce`=1, `o_rw`=1, `o_wdata_oe`=1, `o_addr`=addr, `o_wdata`=exp.
  - Addr increments each cycle. After addr 63, addr wraps to 0 and the state goes to RD_LATCH.
- RD_LATCH: outputs `o_ce`=1, `o_rw`=0, `o_wdata_oe`=0, `o_addr`=addr. The RAM registers the address. Next state is RD_SAMPLE.
- RD_SAMPLE:
  - Outputs `o_ce`=0, `o_rw`=1, `o_wdata_oe`=0. The RAM drives the latched word.
  - At the closing edge, `i_rdata` is compared with exp(addr).
  - On mismatch, `o_err_cnt` increments. If this is the first mismatch, the fail registers are loaded.
  - If addr≠63: addr increments and the state returns to RD_LATCH.
  - If addr=63 and pass=0: pass becomes 1, addr returns to 0, and the state returns to WR.
  - If addr=63 and pass=1: the state goes to DONE.
- DONE:
  - `o_done`=1 for one cycle.
  - `o_pass`=(`o_err_cnt`==0) is registered on entry and is valid during the `o_done` cycle.
  - Next state is IDLE.
- `i_start` is ignored outside IDLE, including during DONE.
- `o_err_cnt` needs no saturation; the maximum is 128.
- All outputs are registered.

## Timing
- Reset values: state IDLE, `o_ce`=0, `o_rw`=0, `o_addr`=0, `o_wdata`=0, `o_wdata_oe`=0, `o_busy`=0, `o_done`=0, `o_pass`=0, `o_err_cnt`=0, all fail fields 0.
- Cycle numbering: start accepted at edge E0; cycle n is the cycle after edge En-1.
- Pass 0:
  - WR addr k occupies cycle 1+k.
  - Reads occupy cycles 65..192, with RD_LATCH/RD_SAMPLE alternating.
- Pass 1:
  - WR occupies cycles 193..256.
  - Reads occupy cycles 257..384.
- DONE (`o_done`=1) is cycle 385. IDLE resumes at cycle 386.
- `o_busy`=1 exactly in cycles 1..384.
- Latency from start to `o_done` is 385 cycles, fixed and data-independent.
- Reset asserted mid-test takes effect at the next edge: all outputs return to reset values with no further RAM write, and no `o_done` pulse.
- `o_wdata_oe` and the RAM drive phase (`o_rw`=1, `o_ce`=0) are never both active, so there is no bus contention.

## Test plan
- Reset: assert `i_rst` for 2 cycles, then release. Required: every output equals its reset value, and there is no RAM activity while `i_start`=0.
- Clean run with a fault-free RAM model, seed 8'h3C. Required:
  - `o_done` is high in cycle 385.
  - `o_pass`=1 and `o_err_cnt`=0.
  - The write in pass 0 at addr 63 carries data 8'h7B; the write in pass 1 at addr 63 carries 8'h84.
- Wrap arithmetic with seed 8'hFF. Required: write data at addr 0 is 8'hFF; at addr 1 it is 8'h00; at addr 63 it is 8'h3E. The test ends with `o_pass`=1.
- Stuck-at fault, seed 8'h00, model with bit 3 stuck at 0 at addr 5. Required:
  - `o_err_cnt`=1 and `o_pass`=0.
  - `o_fail_addr`=5, `o_fail_exp`=8'hFA, `o_fail_got`=8'hF2, `o_fail_pass`=1.
- Start while busy: pulse `i_start` in cycles 10 and 385. Required: both are ignored, the first test completes in cycle 385, and `o_busy` is low in cycle 386.
- Reset mid-test: assert `i_rst` in cycle 100. Required: reset values appear at the next edge and there is no `o_done`. A subsequent start completes a clean test.
